// File: rtl/utils_pkg.sv
// Types shared by the sprite datapath blocks.
package utils_pkg;

    typedef enum logic [2:0] {DirIdle, DirUp, DirDown, DirLeft, DirRight} direction_t;

    // A "no request" want and a stopped heading share the same encoding.
    localparam direction_t DirNone = DirIdle;

endpackage

// File: rtl/pacman_motion_ctrl_if.sv
// Wall-probe handshake between the motion controller (master) and the maze lookup (slave).
interface pacman_motion_ctrl_if;

    logic       wall_req;
    logic [9:0] wall_x;
    logic [9:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;

    modport master (output wall_req, wall_x, wall_y, input wall_ack, wall_hit);
    modport slave  (input wall_req, wall_x, wall_y, output wall_ack, wall_hit);

endinterface

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man per-frame motion controller: steps the sprite during vertical blanking, wall-probed.
// Optional macro PACMAN_TURN_BUFFER_EN keeps a requested turn after the buttons are released.
module pacman_motion_ctrl
    import utils_pkg::*;
#(
    parameter logic [9:0]  X_START     = 10'd320,
    parameter logic [9:0]  Y_START     = 10'd240,
    parameter int unsigned STEP_FRAMES = 2,
    parameter int unsigned RADIUS      = 7,
    parameter logic [9:0]  V_BLANK     = 10'd480,
    parameter logic [9:0]  X_WRAP_LO   = 10'd16,
    parameter logic [9:0]  X_WRAP_HI   = 10'd624
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  h_count,
    input  logic [9:0]                  v_count,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    pacman_motion_ctrl_if.master        wall,
    output logic [9:0]                  x_pos,
    output logic [9:0]                  y_pos,
    output direction_t                  dir,
    output logic                        step_done
);

    localparam int unsigned    CntW   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STEP_FRAMES - 1);
    localparam logic [9:0]     Reach  = 10'(RADIUS + 1);

    typedef enum logic [2:0] {StWait, StProbeWant, StProbeCur, StMove, StStop} state_t;

    state_t        state_q, state_d;
    direction_t    want_q, want_d, btn_dir;
    direction_t    dir_q, dir_d, probe_dir_q, probe_dir_d, issue_dir;
    logic [9:0]    x_q, x_d, y_q, y_d, wx_q, wx_d, wy_q, wy_d;
    logic          req_q, req_d, done_q, done_d, issue;
    logic          vb_q, tick, step_tick;
    logic [CntW-1:0] cnt_q;

    logic unused_h_count;
    assign unused_h_count = ^h_count;

    function automatic logic [9:0] probe_x(direction_t d, logic [9:0] x);
        case (d)
            DirLeft:  probe_x = x - Reach;
            DirRight: probe_x = x + Reach;
            default:  probe_x = x;
        endcase
    endfunction

    function automatic logic [9:0] probe_y(direction_t d, logic [9:0] y);
        case (d)
            DirUp:   probe_y = y - Reach;
            DirDown: probe_y = y + Reach;
            default: probe_y = y;
        endcase
    endfunction

    function automatic logic [9:0] step_x(direction_t d, logic [9:0] x);
        case (d)
            DirLeft:  step_x = (x == X_WRAP_LO) ? X_WRAP_HI : x - 10'd1;
            DirRight: step_x = (x == X_WRAP_HI) ? X_WRAP_LO : x + 10'd1;
            default:  step_x = x;
        endcase
    endfunction

    function automatic logic [9:0] step_y(direction_t d, logic [9:0] y);
        case (d)
            DirUp:   step_y = y - 10'd1;
            DirDown: step_y = y + 10'd1;
            default: step_y = y;
        endcase
    endfunction

    // Rising edge of the blanking-line compare gives one tick per frame.
    assign tick      = (v_count == V_BLANK) && !vb_q;
    assign step_tick = tick && (cnt_q == CntMax);

    always_comb begin
        if (btn_up)         btn_dir = DirUp;
        else if (btn_down)  btn_dir = DirDown;
        else if (btn_left)  btn_dir = DirLeft;
        else if (btn_right) btn_dir = DirRight;
        else                btn_dir = DirNone;
    end

`ifdef PACMAN_TURN_BUFFER_EN
    logic adopt;
    // Only clear the buffered turn if it is still the one that was just taken.
    assign adopt = (state_q == StProbeWant) && wall.wall_ack && !wall.wall_hit &&
                   (want_q == probe_dir_q);

    always_comb begin
        want_d = want_q;
        if (btn_dir != DirNone) want_d = btn_dir;
        else if (adopt)         want_d = DirNone;
    end
`else
    assign want_d = btn_dir;
`endif

    always_comb begin
        state_d     = state_q;
        probe_dir_d = probe_dir_q;
        req_d       = req_q;
        wx_d        = wx_q;
        wy_d        = wy_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        issue_dir   = DirIdle;

        unique case (state_q)
            StWait: begin
                if (step_tick) begin
                    if (want_q != DirNone && want_q != dir_q) begin
                        state_d   = StProbeWant;
                        issue     = 1'b1;
                        issue_dir = want_q;
                    end else if (dir_q != DirIdle) begin
                        state_d   = StProbeCur;
                        issue     = 1'b1;
                        issue_dir = dir_q;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StProbeWant, StProbeCur: begin
                if (wall.wall_ack) begin
                    req_d = 1'b0;
                    if (!wall.wall_hit) begin
                        // Result lands in the cycle after ack; MOVE is the settle cycle.
                        dir_d   = probe_dir_q;
                        x_d     = step_x(probe_dir_q, x_q);
                        y_d     = step_y(probe_dir_q, y_q);
                        done_d  = 1'b1;
                        state_d = StMove;
                    end else if (state_q == StProbeWant && dir_q != DirIdle) begin
                        state_d   = StProbeCur;
                        issue     = 1'b1;
                        issue_dir = dir_q;
                    end else begin
                        dir_d   = DirIdle;
                        done_d  = 1'b1;
                        state_d = StStop;
                    end
                end
            end
            StMove, StStop: state_d = StWait;
            default:        state_d = StWait;
        endcase

        if (issue) begin
            req_d       = 1'b1;
            probe_dir_d = issue_dir;
            wx_d        = probe_x(issue_dir, x_q);
            wy_d        = probe_y(issue_dir, y_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWait;
            want_q      <= DirNone;
            dir_q       <= DirIdle;
            probe_dir_q <= DirIdle;
            x_q         <= X_START;
            y_q         <= Y_START;
            wx_q        <= '0;
            wy_q        <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            vb_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            want_q      <= want_d;
            dir_q       <= dir_d;
            probe_dir_q <= probe_dir_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            req_q       <= req_d;
            done_q      <= done_d;
            vb_q        <= (v_count == V_BLANK);
            if (tick) cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign wall.wall_req = req_q;
    assign wall.wall_x   = wx_q;
    assign wall.wall_y   = wy_q;
    assign x_pos         = x_q;
    assign y_pos         = y_q;
    assign dir           = dir_q;
    assign step_done     = done_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: directed table, corner sequences and a randomized model check.
module tb_pacman_motion_ctrl;
    import utils_pkg::*;

    localparam int STEP_FRAMES = 2;
    localparam int REACH       = 8;
    localparam int WRAP_LO     = 16;
    localparam int WRAP_HI     = 624;

    typedef struct { int x; int y; } pt_t;
    typedef struct {
        logic [3:0] btn;
        int         frames;
        int         wx;
        int         wy;
        int         ex;
        int         ey;
        direction_t edir;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic [3:0] btn = '0;  // {up, down, left, right}
    logic [9:0] x_pos, y_pos;
    direction_t dir;
    logic       step_done;

    pacman_motion_ctrl_if wall_if();

    pacman_motion_ctrl #(.STEP_FRAMES(STEP_FRAMES)) dut (
        .clk       (clk),
        .reset     (reset),
        .h_count   (h_count),
        .v_count   (v_count),
        .btn_up    (btn[3]),
        .btn_down  (btn[2]),
        .btn_left  (btn[1]),
        .btn_right (btn[0]),
        .wall      (wall_if),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .dir       (dir),
        .step_done (step_done)
    );

    initial forever #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   unstable = 0;
    int   ack_delay = 1;
    bit   resp_en = 1'b1;
    bit   force_ack = 1'b0;
    bit   hash_en = 1'b0;
    pt_t  walls[$];
    pt_t  probes[$];
    vec_t vecs[10];

    int         m_x, m_y, ticks;
    direction_t m_dir, m_want;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit is_wall(input int x, input int y);
        foreach (walls[i]) if (walls[i].x == x && walls[i].y == y) return 1'b1;
        if (hash_en && ((x * 3 + y * 5) % 11 == 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Maze lookup: acks after ack_delay extra cycles and logs every probe.
    initial begin
        int  wait_cnt = 0;
        pt_t cap;
        wall_if.wall_ack = 1'b0;
        wall_if.wall_hit = 1'b0;
        forever begin
            @(negedge clk);
            wall_if.wall_ack = 1'b0;
            wall_if.wall_hit = 1'b0;
            if (force_ack) begin
                wall_if.wall_ack = 1'b1;
            end else if (resp_en && wall_if.wall_req && !reset) begin
                if (wait_cnt == 0) begin
                    cap.x = int'(wall_if.wall_x);
                    cap.y = int'(wall_if.wall_y);
                end else if (int'(wall_if.wall_x) != cap.x || int'(wall_if.wall_y) != cap.y) begin
                    unstable++;
                end
                if (wait_cnt >= ack_delay) begin
                    wall_if.wall_ack = 1'b1;
                    wall_if.wall_hit = is_wall(cap.x, cap.y);
                    probes.push_back(cap);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (step_done) done_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn = '0;
        v_count = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        walls.delete();
    endtask

    // One frame: v_count sits on the blanking line for two cycles, then gap idle cycles.
    task automatic frame(input int gap);
        @(negedge clk);
        v_count = 10'd480;
        repeat (2) @(negedge clk);
        v_count = 10'd0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic direction_t prio(input logic [3:0] b);
        if (b[3]) return DirUp;
        if (b[2]) return DirDown;
        if (b[1]) return DirLeft;
        if (b[0]) return DirRight;
        return DirNone;
    endfunction

    function automatic pt_t probe_pt(input direction_t d, input int x, input int y);
        pt_t p;
        p.x = x;
        p.y = y;
        case (d)
            DirUp:    p.y = (y - REACH + 1024) % 1024;
            DirDown:  p.y = (y + REACH) % 1024;
            DirLeft:  p.x = (x - REACH + 1024) % 1024;
            DirRight: p.x = (x + REACH) % 1024;
            default:  ;
        endcase
        return p;
    endfunction

    function automatic bit m_blocked(input direction_t d);
        pt_t p = probe_pt(d, m_x, m_y);
        return is_wall(p.x, p.y);
    endfunction

    function automatic void m_move(input direction_t d);
        case (d)
            DirLeft:  m_x = (m_x == WRAP_LO) ? WRAP_HI : m_x - 1;
            DirRight: m_x = (m_x == WRAP_HI) ? WRAP_LO : m_x + 1;
            DirUp:    m_y = m_y - 1;
            DirDown:  m_y = m_y + 1;
            default:  ;
        endcase
    endfunction

    // Reference step decision straight from the movement rules.
    function automatic bit model_step();
        bit adopted = 1'b0;
        if (m_want != DirNone && m_want != m_dir) begin
            if (!m_blocked(m_want)) begin
                m_dir = m_want;
                m_move(m_dir);
                adopted = 1'b1;
            end else if (m_dir != DirIdle) begin
                if (!m_blocked(m_dir)) m_move(m_dir);
                else m_dir = DirIdle;
            end
        end else if (m_dir != DirIdle) begin
            if (!m_blocked(m_dir)) m_move(m_dir);
            else m_dir = DirIdle;
        end
        return adopted;
    endfunction

    initial begin
        int base_done, base_probe;

        vecs[0] = '{4'b0000, 4, 0, 0, 320, 240, DirIdle};
        vecs[1] = '{4'b0001, 4, 0, 0, 322, 240, DirRight};
        vecs[2] = '{4'b1000, 4, 0, 0, 320, 238, DirUp};
        vecs[3] = '{4'b0010, 2, 0, 0, 319, 240, DirLeft};
        vecs[4] = '{4'b0100, 6, 0, 0, 320, 243, DirDown};
        vecs[5] = '{4'b1010, 2, 0, 0, 320, 239, DirUp};
        vecs[6] = '{4'b0101, 2, 0, 0, 320, 241, DirDown};
        vecs[7] = '{4'b0011, 2, 0, 0, 319, 240, DirLeft};
        vecs[8] = '{4'b0001, 4, 328, 240, 320, 240, DirIdle};
        vecs[9] = '{4'b0001, 4, 329, 240, 321, 240, DirIdle};

        // Reset values
        do_reset();
        check("rst_x", int'(x_pos), 320);
        check("rst_y", int'(y_pos), 240);
        check("rst_dir", int'(dir), int'(DirIdle));
        check("rst_req", int'(wall_if.wall_req), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_wall_x", int'(wall_if.wall_x), 0);
        check("rst_wall_y", int'(wall_if.wall_y), 0);

        // Table-driven single-button scenarios, each from reset
        ack_delay = 1;
        foreach (vecs[i]) begin
            do_reset();
            walls.push_back('{vecs[i].wx, vecs[i].wy});
            base_done = done_cnt;
            btn = vecs[i].btn;
            repeat (vecs[i].frames) frame(8);
            check($sformatf("vec%0d_x", i), int'(x_pos), vecs[i].ex);
            check($sformatf("vec%0d_y", i), int'(y_pos), vecs[i].ey);
            check($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].edir));
            check($sformatf("vec%0d_done", i), done_cnt - base_done, vecs[i].frames / 2);
        end

        // Open field probe coordinates, then a blocked turn from there
        do_reset();
        base_probe = probes.size();
        btn = 4'b0001;
        repeat (4) frame(8);
        check("open_nprobe", probes.size() - base_probe, 2);
        if (probes.size() - base_probe == 2) begin
            check("open_p0_x", probes[base_probe].x, 328);
            check("open_p1_x", probes[base_probe + 1].x, 329);
            check("open_p1_y", probes[base_probe + 1].y, 240);
        end
        walls.push_back('{322, 232});
        base_probe = probes.size();
        base_done = done_cnt;
        btn = 4'b1000;
        repeat (2) frame(8);
        check("blk_dir", int'(dir), int'(DirRight));
        check("blk_x", int'(x_pos), 323);
        check("blk_y", int'(y_pos), 240);
        check("blk_nprobe", probes.size() - base_probe, 2);
        check("blk_done", done_cnt - base_done, 1);

        // Dead end: heading LEFT, turn and current both blocked
        do_reset();
        btn = 4'b0010;
        repeat (2) frame(8);
        walls.push_back('{319, 232});
        walls.push_back('{311, 240});
        base_done = done_cnt;
        btn = 4'b1000;
        repeat (2) frame(8);
        check("dead_dir", int'(dir), int'(DirIdle));
        check("dead_x", int'(x_pos), 319);
        check("dead_y", int'(y_pos), 240);
        check("dead_done", done_cnt - base_done, 1);

        // Tunnel wrap both ways
        do_reset();
        ack_delay = 0;
        btn = 4'b0001;
        repeat (2 * (WRAP_HI - 320)) frame(4);
        check("tun_pre_x", int'(x_pos), WRAP_HI);
        repeat (2) frame(4);
        check("tun_r_x", int'(x_pos), WRAP_LO);
        btn = 4'b0010;
        repeat (2) frame(4);
        check("tun_l_x", int'(x_pos), WRAP_HI);
        check("tun_l_dir", int'(dir), int'(DirLeft));

        // Slow ack: probe stays stable and an overrun tick is dropped
        do_reset();
        ack_delay = 50;
        unstable = 0;
        base_probe = probes.size();
        btn = 4'b0001;
        repeat (4) frame(2);
        repeat (60) @(negedge clk);
        check("slow_x", int'(x_pos), 321);
        check("slow_nprobe", probes.size() - base_probe, 1);
        check("slow_stable", unstable, 0);
        ack_delay = 1;
        frame(2);
        frame(8);
        check("slow_next_x", int'(x_pos), 322);
        check("slow_next_nprobe", probes.size() - base_probe, 2);

        // Reset with a probe outstanding, then a stray ack
        do_reset();
        ack_delay = 50;
        btn = 4'b0001;
        frame(2);
        frame(2);
        check("rreq_pre", int'(wall_if.wall_req), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rreq_low", int'(wall_if.wall_req), 0);
        reset = 1'b0;
        base_done = done_cnt;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_req", int'(wall_if.wall_req), 0);
        check("stray_x", int'(x_pos), 320);
        check("stray_dir", int'(dir), int'(DirIdle));
        check("stray_done", done_cnt - base_done, 0);
        ack_delay = 1;

        // One-cycle tap at a blocked spot, wall opens later
        do_reset();
        walls.push_back('{320, 248});
        @(negedge clk);
        btn = 4'b0100;
        @(negedge clk);
        btn = 4'b0000;
        repeat (2) frame(8);
        check("tap_blk_dir", int'(dir), int'(DirIdle));
        walls.delete();
        repeat (4) frame(8);
`ifdef PACMAN_TURN_BUFFER_EN
        check("tap_dir", int'(dir), int'(DirDown));
        check("tap_y", int'(y_pos), 242);
`else
        check("tap_dir", int'(dir), int'(DirIdle));
        check("tap_y", int'(y_pos), 240);
`endif

        // Randomized buttons, ack latency and maze against the reference model
        do_reset();
        hash_en = 1'b1;
        m_x = 320;
        m_y = 240;
        m_dir = DirIdle;
        m_want = DirNone;
        ticks = 0;
        base_done = done_cnt;
        for (int f = 0; f < 80; f++) begin
            bit adopted;
            @(negedge clk);
            btn = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            ack_delay = $urandom_range(0, 3);
            frame(12);
            ticks++;
`ifdef PACMAN_TURN_BUFFER_EN
            if (prio(btn) != DirNone) m_want = prio(btn);
`else
            m_want = prio(btn);
`endif
            if (ticks % STEP_FRAMES == 0) begin
                adopted = model_step();
`ifdef PACMAN_TURN_BUFFER_EN
                if (adopted && prio(btn) == DirNone) m_want = DirNone;
`endif
            end
            check($sformatf("rnd%0d_x", f), int'(x_pos), m_x);
            check($sformatf("rnd%0d_y", f), int'(y_pos), m_y);
            check($sformatf("rnd%0d_dir", f), int'(dir), int'(m_dir));
        end
        check("rnd_done", done_cnt - base_done, ticks / STEP_FRAMES);
        check("all_stable", unstable, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pacman_motion_ctrl.md
# pacman_motion_ctrl

Per-frame motion controller for the Pac-Man sprite. It latches joystick direction requests and steps the sprite position once every `STEP_FRAMES` frames during vertical blanking. Each step checks walls through a request/acknowledge probe to the maze lookup. It drives the `x_pos`, `y_pos` and `dir` inputs of the Pac-Man sprite renderer and is the only writer of those signals.

## Interface
- `X_START`, default 320: x_pos after reset (10-bit).
- `Y_START`, default 240: y_pos after reset (10-bit).
- `STEP_FRAMES`, default 2: frames per 1-pixel step, ≥1.
- `RADIUS`, default 7: sprite radius; the probe point is placed at `RADIUS+1` from the centre.
- `V_BLANK`, default 480: v_count value that marks the frame tick.
- `X_WRAP_LO`, default 16: tunnel left x.
- `X_WRAP_HI`, default 624: tunnel right x.

Ports:
- `clk` in 1: system clock; the single clock.
- `reset` in 1: synchronous, active-high.
- `h_count` in 10: from VGA control.
- `v_count` in 10: from VGA control.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: joystick inputs, level.
- `wall_ack` in 1: maze lookup response valid, single-cycle pulse.
- `wall_hit` in 1: probe point is a wall; sampled only when `wall_ack` is high.
- `wall_req` out 1: probe request, held until acknowledged.
- `wall_x`, `wall_y` out 10 each: probe point, stable while `wall_req` is high.
- `x_pos`, `y_pos` out 10 each: sprite centre.
- `dir` out `direction_t` (utils package): current heading; IDLE when stopped.
- `step_done` out 1: one-cycle pulse per completed step decision.

## Operation
- **Frame tick:** rising edge of (`v_count == V_BLANK`), detected with a registered compare. Exactly one tick per frame, independent of the pixel-enable rate.
- **Frame counter:** counts ticks 0..STEP_FRAMES-1. A step starts on the tick where the counter wraps to 0.
- **Want register:** holds the requested direction.
  - Priority when several buttons are pressed: UP > DOWN > LEFT > RIGHT.
  - A new press overwrites the register.
  - Release behaviour depends on the Configuration section.
- **FSM states:**
  - WAIT: idle until a step tick. Then go to PROBE_WANT if want ≠ NONE and want ≠ dir; else to PROBE_CUR if dir ≠ IDLE; else emit `step_done` and stay in WAIT.
  - PROBE_WANT: assert `wall_req` with the probe for want. On ack: if no hit, dir←want and go to MOVE; if hit, go to PROBE_CUR, or to STOP when dir is IDLE.
  - PROBE_CUR: probe for the current dir. On ack: if no hit, go to MOVE; if hit, go to STOP.
  - MOVE: apply a 1-pixel step in dir, pulse `step_done`, return to WAIT.
  - STOP: set dir←IDLE, position unchanged, pulse `step_done`, return to WAIT.
- **Probe point:** (x_pos ± (RADIUS+1), y_pos) for RIGHT/LEFT; (x_pos, y_pos ± (RADIUS+1)) for DOWN/UP. Computed modulo 1024 in 10 bits; the maze treats out-of-range coordinates as non-wall.
- **Tunnel wrap:**
  - LEFT step at x_pos == X_WRAP_LO sets x_pos to X_WRAP_HI.
  - RIGHT step at x_pos == X_WRAP_HI sets x_pos to X_WRAP_LO.
  - All other steps are ±1 with no wrap.
- **Handshake rules:**
  - `wall_req`, `wall_x` and `wall_y` are registered outputs and do not change while `wall_req` is high.
  - `wall_ack` while `wall_req` is low is ignored.
  - There is no timeout: the FSM waits for `wall_ack` indefinitely.
- **Overrun:** a step tick arriving while the FSM is not in WAIT is dropped. The frame counter still advances.

## Timing
- **Reset values:** x_pos=X_START, y_pos=Y_START, dir=IDLE, want=NONE, wall_req=0, wall_x=0, wall_y=0, step_done=0, state=WAIT, frame counter=0.
- **Reset mid-operation:** an outstanding probe is abandoned. `wall_req` is low at the first edge after reset, and a late ack is ignored.
- **Single-probe step:**
  - Tick detected in cycle T.
  - `wall_req` rises in cycle T+1.
  - Ack in cycle A.
  - `wall_req` is low and x_pos/y_pos/dir and `step_done` are updated in cycle A+1.
- **Two-probe step:** after the first ack in cycle A, the second `wall_req` is high in cycle A+1 with the new probe coordinates. Results become visible in the cycle after the second ack.
- **Output stability:** position and dir change only in the MOVE or STOP cycle, which is outside the active display because the update runs during blanking.

## Configuration
- **`PACMAN_TURN_BUFFER_EN` defined:** want persists after all buttons are released. It clears only when it is adopted into dir or overwritten by a new press, which allows pre-turning before a junction.
- **Undefined:** want mirrors the buttons each cycle and is NONE when none are pressed. A blocked turn is lost on release.

## Test plan
- **Reset:** assert reset for 3 cycles → x_pos=320, y_pos=240, dir=IDLE, wall_req=0, step_done=0.
- **Open field:** hold btn_right, wall_hit=0, ack one cycle after req, 4 frames at STEP_FRAMES=2 → dir=RIGHT, x_pos=322, y_pos=240; probes at (328,240) then (329,240).
- **Blocked turn:** dir=RIGHT, hold btn_up, UP probe hit=1, RIGHT probe hit=0 → dir stays RIGHT, x_pos+1, two req/ack pairs in the same frame.
- **Dead end:** dir=LEFT, both probes hit=1 → dir=IDLE, position unchanged, step_done pulses once.
- **Tunnel:** x_pos=624, dir=RIGHT, no walls → x_pos=16 after the step. LEFT at x_pos=16 → x_pos=624.
- **Handshake and reset edge cases:**
  - Delay ack by 50 cycles → wall_x/wall_y stay constant, and a tick during the wait is dropped.
  - Reset while wall_req=1 → wall_req low next cycle, and a stray ack is ignored.
  - With `PACMAN_TURN_BUFFER_EN`: tap btn_down for 1 cycle at a blocked position, open the wall 3 frames later → dir=DOWN.
